// File: rtl/mem_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : mem_issue_queue
//  Brief    : In-order issue queue for loads/stores ahead of the memory pipe.
//  Revision : 1.0
// ============================================================================

package mem_iq_pkg;
    typedef struct packed {
        logic        i_valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
    } instr_pkt;
endpackage

module mem_issue_queue
    import mem_iq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PHYS_W    = 6,
    parameter int CDB_PORTS = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               br_flush,
    input  logic                               disp_valid,
    output logic                               disp_ready,
    input  instr_pkt                           disp_pkt,
    input  logic                               disp_is_store,
    input  logic [PHYS_W-1:0]                  disp_ps1,
    input  logic [PHYS_W-1:0]                  disp_ps2,
    input  logic                               disp_ps1_rdy,
    input  logic                               disp_ps2_rdy,
    input  logic [CDB_PORTS-1:0]               cdb_valid,
    input  logic [CDB_PORTS-1:0][PHYS_W-1:0]   cdb_pd,
    input  logic                               stall_load,
    input  logic                               stall_store,
    output instr_pkt                           mem_iss,
    output logic                               is_store,
    output logic [PHYS_W-1:0]                  iss_ps1,
    output logic [PHYS_W-1:0]                  iss_ps2,
    output logic                               stall_mem_latch,
    output logic [$clog2(DEPTH):0]             count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DEPTH-1:0]   r_valid;
    logic [DEPTH-1:0]   r_rdy1;
    logic [DEPTH-1:0]   r_rdy2;
    logic [DEPTH-1:0]   r_store;
    instr_pkt           r_pkt [DEPTH];
    logic [PHYS_W-1:0]  r_ps1 [DEPTH];
    logic [PHYS_W-1:0]  r_ps2 [DEPTH];
    logic [c_PTR_W-1:0] r_head;
    logic [c_PTR_W-1:0] r_tail;
    logic [c_CNT_W-1:0] r_count;
    logic               r_stall_latch;

    logic [DEPTH-1:0]   w_wake1;
    logic [DEPTH-1:0]   w_wake2;
    logic               w_enq;
    logic               w_enq_rdy1;
    logic               w_enq_rdy2;
    logic               w_head_valid;
    logic               w_head_opready;
    logic               w_head_stalled;
    logic               w_issue;

    // Tag 0 is the hardwired-ready register and must never be woken by the CDB.
    function automatic logic f_cdb_hit(
        input logic [PHYS_W-1:0]                tag,
        input logic [CDB_PORTS-1:0]             vld,
        input logic [CDB_PORTS-1:0][PHYS_W-1:0] pd
    );
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (vld[p] && (pd[p] == tag)) begin
                hit = 1'b1;
            end
        end
        return hit && (tag != '0);
    endfunction

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_wake
            assign w_wake1[g] = f_cdb_hit(r_ps1[g], cdb_valid, cdb_pd);
            assign w_wake2[g] = f_cdb_hit(r_ps2[g], cdb_valid, cdb_pd);
        end
    endgenerate

    assign disp_ready     = (r_count < c_CNT_W'(DEPTH));
    assign w_enq          = disp_valid && disp_ready && !br_flush;
    assign w_enq_rdy1     = disp_ps1_rdy || f_cdb_hit(disp_ps1, cdb_valid, cdb_pd);
    assign w_enq_rdy2     = !disp_is_store || disp_ps2_rdy || f_cdb_hit(disp_ps2, cdb_valid, cdb_pd);

    assign w_head_valid   = r_valid[r_head];
    assign w_head_opready = w_head_valid && r_rdy1[r_head] && r_rdy2[r_head];
    assign w_head_stalled = r_store[r_head] ? stall_store : stall_load;
    assign w_issue        = w_head_opready && !w_head_stalled && !br_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid       <= '0;
            r_rdy1        <= '0;
            r_rdy2        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_stall_latch <= 1'b0;
        end else if (br_flush) begin
            r_valid       <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_stall_latch <= 1'b0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_wake1[e]) r_rdy1[e] <= 1'b1;
                if (w_wake2[e]) r_rdy2[e] <= 1'b1;
            end
            if (w_issue) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + c_PTR_W'(1);
            end
            // Enqueue never targets the head slot while it is valid (no full-bypass).
            if (w_enq) begin
                r_valid[r_tail] <= 1'b1;
                r_rdy1[r_tail]  <= w_enq_rdy1;
                r_rdy2[r_tail]  <= w_enq_rdy2;
                r_tail          <= r_tail + c_PTR_W'(1);
            end
            case ({w_enq, w_issue})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_stall_latch <= w_head_opready && w_head_stalled;
        end
    end

    // Payload needs no reset: it is only observed behind a valid bit.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_pkt[r_tail]   <= disp_pkt;
            r_store[r_tail] <= disp_is_store;
            r_ps1[r_tail]   <= disp_ps1;
            r_ps2[r_tail]   <= disp_ps2;
        end
    end

    always_comb begin
        mem_iss  = '0;
        is_store = 1'b0;
        iss_ps1  = '0;
        iss_ps2  = '0;
        if (w_head_valid) begin
            mem_iss  = r_pkt[r_head];
            is_store = r_store[r_head];
            iss_ps1  = r_ps1[r_head];
            iss_ps2  = r_ps2[r_head];
        end
        mem_iss.i_valid = w_issue;
    end

    assign stall_mem_latch = r_stall_latch;
    assign count           = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mem_issue_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_issue_queue
//  Brief    : Self-checking bench for mem_issue_queue against a queue model.
//  Revision : 1.0
// ============================================================================

module tb_mem_issue_queue;
    import mem_iq_pkg::*;

    localparam int DEPTH     = 8;
    localparam int PHYS_W    = 6;
    localparam int CDB_PORTS = 3;

    logic                             clk = 1'b0;
    logic                             rst = 1'b1;
    logic                             br_flush = 1'b0;
    logic                             disp_valid = 1'b0;
    logic                             disp_ready;
    instr_pkt                         disp_pkt = '0;
    logic                             disp_is_store = 1'b0;
    logic [PHYS_W-1:0]                disp_ps1 = '0;
    logic [PHYS_W-1:0]                disp_ps2 = '0;
    logic                             disp_ps1_rdy = 1'b0;
    logic                             disp_ps2_rdy = 1'b0;
    logic [CDB_PORTS-1:0]             cdb_valid = '0;
    logic [CDB_PORTS-1:0][PHYS_W-1:0] cdb_pd = '0;
    logic                             stall_load = 1'b0;
    logic                             stall_store = 1'b0;
    instr_pkt                         mem_iss;
    logic                             is_store;
    logic [PHYS_W-1:0]                iss_ps1;
    logic [PHYS_W-1:0]                iss_ps2;
    logic                             stall_mem_latch;
    logic [$clog2(DEPTH):0]           count;

    always #5 clk = ~clk;

    mem_issue_queue #(.DEPTH(DEPTH), .PHYS_W(PHYS_W), .CDB_PORTS(CDB_PORTS)) dut (
        .clk(clk), .rst(rst), .br_flush(br_flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_pkt(disp_pkt),
        .disp_is_store(disp_is_store), .disp_ps1(disp_ps1), .disp_ps2(disp_ps2),
        .disp_ps1_rdy(disp_ps1_rdy), .disp_ps2_rdy(disp_ps2_rdy),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
        .stall_load(stall_load), .stall_store(stall_store),
        .mem_iss(mem_iss), .is_store(is_store), .iss_ps1(iss_ps1), .iss_ps2(iss_ps2),
        .stall_mem_latch(stall_mem_latch), .count(count)
    );

    typedef struct {
        instr_pkt          pkt;
        logic              st;
        logic [PHYS_W-1:0] ps1;
        logic [PHYS_W-1:0] ps2;
        logic              r1;
        logic              r2;
    } ent_t;

    ent_t q[$];
    logic m_latch = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Staged stimulus, applied just after the next rising edge.
    logic                             s_flush, s_dv, s_st, s_r1, s_r2, s_sl, s_ss;
    instr_pkt                         s_pkt;
    logic [PHYS_W-1:0]                s_ps1, s_ps2;
    logic [CDB_PORTS-1:0]             s_cv;
    logic [CDB_PORTS-1:0][PHYS_W-1:0] s_cpd;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic hit(input logic [PHYS_W-1:0] t);
        logic h;
        h = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (s_cv[p] && s_cpd[p] == t && t != 0) h = 1'b1;
        end
        return h;
    endfunction

    function automatic instr_pkt rand_pkt();
        instr_pkt p;
        p.i_valid  = 1'b0;
        p.pc       = $urandom;
        p.inst     = $urandom;
        p.rd       = 5'($urandom_range(0, 31));
        p.imm      = $urandom;
        p.rs1_data = $urandom;
        p.rs2_data = $urandom;
        return p;
    endfunction

    task automatic idle();
        s_flush = 0; s_dv = 0; s_st = 0; s_r1 = 0; s_r2 = 0; s_sl = 0; s_ss = 0;
        s_pkt = '0; s_ps1 = '0; s_ps2 = '0; s_cv = '0; s_cpd = '0;
    endtask

    task automatic disp(input logic st, input int ps1, input logic r1, input int ps2, input logic r2);
        idle();
        s_dv = 1; s_st = st; s_pkt = rand_pkt();
        s_ps1 = PHYS_W'(ps1); s_r1 = r1; s_ps2 = PHYS_W'(ps2); s_r2 = r2;
    endtask

    // One clock: apply stimulus, check outputs against the model, advance the model.
    task automatic step();
        logic hok, stl, iv, rdy;
        ent_t e;
        @(posedge clk); #1;
        br_flush = s_flush; disp_valid = s_dv; disp_pkt = s_pkt; disp_is_store = s_st;
        disp_ps1 = s_ps1; disp_ps2 = s_ps2; disp_ps1_rdy = s_r1; disp_ps2_rdy = s_r2;
        cdb_valid = s_cv; cdb_pd = s_cpd; stall_load = s_sl; stall_store = s_ss;
        @(negedge clk);
        rdy = (q.size() < DEPTH);
        hok = 0; stl = 0;
        if (q.size() > 0) begin
            hok = q[0].r1 && q[0].r2;
            stl = q[0].st ? s_ss : s_sl;
        end
        iv = hok && !stl && !s_flush;
        chk("disp_ready", 64'(disp_ready), 64'(rdy));
        chk("count", 64'(count), 64'(q.size()));
        chk("stall_mem_latch", 64'(stall_mem_latch), 64'(m_latch));
        chk("i_valid", 64'(mem_iss.i_valid), 64'(iv));
        if (q.size() > 0) begin
            chk("is_store", 64'(is_store), 64'(q[0].st));
            chk("iss_ps1", 64'(iss_ps1), 64'(q[0].ps1));
            chk("iss_ps2", 64'(iss_ps2), 64'(q[0].ps2));
        end
        if (iv) chk("pkt", {mem_iss.pc, mem_iss.inst}, {q[0].pkt.pc, q[0].pkt.inst});
        if (s_flush) begin
            q.delete();
            m_latch = 0;
        end else begin
            m_latch = hok && stl;
            foreach (q[i]) begin
                if (hit(q[i].ps1)) q[i].r1 = 1;
                if (hit(q[i].ps2)) q[i].r2 = 1;
            end
            if (iv) void'(q.pop_front());
            if (s_dv && rdy) begin
                e.pkt = s_pkt; e.st = s_st; e.ps1 = s_ps1; e.ps2 = s_ps2;
                e.r1  = s_r1 || hit(s_ps1);
                e.r2  = !s_st || s_r2 || hit(s_ps2);
                q.push_back(e);
            end
        end
    endtask

    task automatic lit_reset(input string tag);
        chk({tag, "_count"}, 64'(count), 64'd0);
        chk({tag, "_disp_ready"}, 64'(disp_ready), 64'd1);
        chk({tag, "_i_valid"}, 64'(mem_iss.i_valid), 64'd0);
        chk({tag, "_is_store"}, 64'(is_store), 64'd0);
        chk({tag, "_iss_ps"}, {iss_ps1, iss_ps2}, 64'd0);
        chk({tag, "_latch"}, 64'(stall_mem_latch), 64'd0);
    endtask

    task automatic drain(input int n);
        idle();
        repeat (n) step();
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        lit_reset("reset");
        rst = 0;

        // Ready load: issues the cycle after dispatch, then queue empties.
        disp(0, 5, 1, 17, 0); step();
        chk("lat_disp_cycle_iv", 64'(mem_iss.i_valid), 64'd0);
        idle(); step();
        chk("lat_iv", 64'(mem_iss.i_valid), 64'd1);
        chk("lat_is_store", 64'(is_store), 64'd0);
        chk("lat_ps1", 64'(iss_ps1), 64'd5);
        idle(); step();
        chk("lat_count_back", 64'(count), 64'd0);

        // Store waiting on ps2=9, woken by CDB port 2.
        disp(1, 3, 1, 9, 0); step();
        idle(); step();
        chk("wake_before", 64'(mem_iss.i_valid), 64'd0);
        idle(); s_cv = 3'b100; s_cpd[2] = 6'd9; step();
        chk("wake_same_cycle", 64'(mem_iss.i_valid), 64'd0);
        idle(); step();
        chk("wake_next_iv", 64'(mem_iss.i_valid), 64'd1);
        chk("wake_next_ps2", 64'(iss_ps2), 64'd9);
        drain(2);

        // Blocked load at head holds back a ready store behind it.
        disp(0, 12, 0, 0, 0); step();
        disp(1, 0, 1, 0, 1); step();
        drain(3);
        chk("order_blocked", 64'(mem_iss.i_valid), 64'd0);
        idle(); s_cv = 3'b001; s_cpd[0] = 6'd12; step();
        idle(); step();
        chk("order_first_load", {63'd0, mem_iss.i_valid} << 1 | 64'(is_store), 64'd2);
        idle(); step();
        chk("order_then_store", {63'd0, mem_iss.i_valid} << 1 | 64'(is_store), 64'd3);
        drain(2);

        // Fill, drop the ninth dispatch, then free one slot.
        for (int i = 0; i < DEPTH; i++) begin
            disp(0, 20, 0, 0, 0); step();
        end
        disp(0, 21, 1, 0, 0); step();
        chk("full_ready", 64'(disp_ready), 64'd0);
        chk("full_count", 64'(count), 64'd8);
        idle(); s_cv = 3'b010; s_cpd[1] = 6'd20; step();
        idle(); step();
        chk("full_issue", 64'(mem_iss.i_valid), 64'd1);
        idle(); step();
        chk("full_ready_back", 64'(disp_ready), 64'd1);
        chk("full_count_back", 64'(count), 64'd7);
        drain(10);

        // Load stalled three cycles, store behind it blocked throughout.
        disp(0, 0, 1, 0, 0); s_sl = 1; step();
        disp(1, 0, 1, 0, 1); s_sl = 1; step();
        chk("stall_iv0", 64'(mem_iss.i_valid), 64'd0);
        idle(); s_sl = 1; step();
        chk("stall_iv1", 64'(mem_iss.i_valid), 64'd0);
        chk("stall_latch1", 64'(stall_mem_latch), 64'd1);
        idle(); s_sl = 1; step();
        chk("stall_iv2", 64'(mem_iss.i_valid), 64'd0);
        idle(); step();
        chk("stall_release", {63'd0, mem_iss.i_valid} << 1 | 64'(is_store), 64'd2);
        idle(); step();
        chk("stall_store_next", {63'd0, mem_iss.i_valid} << 1 | 64'(is_store), 64'd3);
        drain(2);

        // Flush with five entries and a concurrent dispatch and wakeup.
        for (int i = 0; i < 5; i++) begin
            disp(0, 30, 0, 0, 0); step();
        end
        disp(0, 0, 1, 0, 0); s_flush = 1; s_cv = 3'b001; s_cpd[0] = 6'd30; step();
        chk("flush_iv", 64'(mem_iss.i_valid), 64'd0);
        idle(); step();
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_no_issue", 64'(mem_iss.i_valid), 64'd0);

        // Asynchronous reset with stalled ready entries and the latch set.
        disp(0, 0, 1, 0, 0); s_sl = 1; step();
        disp(0, 0, 1, 0, 0); s_sl = 1; step();
        idle(); s_sl = 1; step();
        chk("pre_rst_latch", 64'(stall_mem_latch), 64'd1);
        @(posedge clk); #2;
        rst = 1;
        #1;
        lit_reset("async_rst");
        q.delete();
        m_latch = 0;
        idle();
        @(posedge clk); #1;
        rst = 0;

        for (int c = 0; c < 3000; c++) begin
            idle();
            s_dv  = ($urandom_range(0, 99) < 60);
            s_st  = 1'($urandom_range(0, 1));
            s_pkt = rand_pkt();
            s_ps1 = PHYS_W'($urandom_range(0, 7));
            s_ps2 = PHYS_W'($urandom_range(0, 7));
            s_r1  = (s_ps1 == 0) || ($urandom_range(0, 2) == 0);
            s_r2  = (s_ps2 == 0) || ($urandom_range(0, 2) == 0);
            s_cv  = CDB_PORTS'($urandom_range(0, 7));
            for (int p = 0; p < CDB_PORTS; p++) s_cpd[p] = PHYS_W'($urandom_range(0, 7));
            s_sl    = ($urandom_range(0, 3) == 0);
            s_ss    = ($urandom_range(0, 3) == 0);
            s_flush = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order issue queue for memory instructions, sitting directly upstream of the execute stage's memory pipe. Dispatched loads and stores are buffered in program order, and their source-tag readiness is tracked via CDB wakeups. The head entry issues onto the `mem_iss` / `is_store` interface when both operands are ready and the memory pipe is not stalled. In-order issue preserves load/store ordering for the execute stage's store buffer and dcache.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; a power of two, at least 2.
- `PHYS_W`, 6: physical register tag width.
- `CDB_PORTS`, 3: number of CDB broadcast ports.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `br_flush`  in  1  squashes all entries.
- `disp_valid`  in  1  dispatch request.
- `disp_ready`  out  1  queue accepts dispatch this cycle.
- `disp_pkt`  in  instr_pkt  decoded memory instruction.
- `disp_is_store`  in  1  1 means store, 0 means load.
- `disp_ps1` / `disp_ps2`  in  PHYS_W  source physical tags.
- `disp_ps1_rdy` / `disp_ps2_rdy`  in  1  source already ready at dispatch.
- `cdb_valid`  in  CDB_PORTS  per-port broadcast valid.
- `cdb_pd`  in  PHYS_W x CDB_PORTS  per-port broadcast tag.
- `stall_load` / `stall_store`  in  1  memory pipe back-pressure from execute.
- `mem_iss`  out  instr_pkt  issued instruction; `i_valid` qualifies it.
- `is_store`  out  1  type of the issued instruction.
- `iss_ps1` / `iss_ps2`  out  PHYS_W  PRF read tags for the issued instruction.
- `stall_mem_latch`  out  1  issue was blocked last cycle by stall_load or stall_store.
- `count`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer with `head` and `tail` pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH, plus `count`.
- Each entry holds: valid, pkt, is_store, ps1, ps2, rdy1, rdy2.
- Dispatch:
  - `disp_ready = (count < DEPTH)`; a dequeue in the same cycle is not considered, so there is no full-bypass.
  - On `disp_valid && disp_ready`, write the entry at `tail` and advance `tail`.
- Readiness at enqueue: `rdy1 = disp_ps1_rdy` OR any `cdb_valid[i] && cdb_pd[i]==disp_ps1` in the same cycle. `rdy2` is computed the same way.
  - Loads ignore rs2: `rdy2` is forced to 1 when `!disp_is_store`.
- Wakeup: every cycle, each valid entry sets `rdyN` when any valid CDB port broadcasts a matching tag.
  - Tag 0 is never broadcast-matched; x0 sources arrive with `*_rdy=1`.
- Issue candidate: the head entry is valid, `rdy1 && rdy2` (registered values only), and `!(is_store ? stall_store : stall_load)`.
- Issue outputs:
  - Outputs are driven combinationally from the head entry: `mem_iss = pkt` with `i_valid` set to the candidate condition, `is_store = head.is_store`, `iss_ps1` / `iss_ps2` = head tags.
  - `rs1_data` / `rs2_data` in `mem_iss` are don't-care; execute reads the PRF.
- On issue, the head entry is invalidated and `head` advances. Younger ready entries never bypass the head.
- `stall_mem_latch` is a flop: set to 1 when the head was operand-ready but blocked by the stall; otherwise 0.
- Flush: `br_flush` clears all valids, sets `head = tail = 0` and `count = 0`, and drops any dispatch in the same cycle. `mem_iss.i_valid` is 0 during the flush cycle.
- Occupancy: `count` goes +1 on enqueue and -1 on issue; simultaneous enqueue and issue leaves it unchanged.

## Timing
- Reset, and the state after it: all valids 0, `head = tail = 0`, `count = 0`, `disp_ready = 1`, `mem_iss.i_valid = 0`, `is_store = 0`, `iss_ps1 = iss_ps2 = 0`, `stall_mem_latch = 0`.
- Minimum latency: dispatch with ready operands in cycle N, issue visible in cycle N+1.
- CDB wakeup in cycle N makes the entry issue-eligible in cycle N+1.
- Full: when `count == DEPTH`, `disp_ready = 0`. `disp_ready` returns to 1 the cycle after an issue.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no gap in issue order.
- Stall: with the head blocked, outputs hold `i_valid = 0` and `head` is unchanged. The instruction issues in the first cycle the stall is deasserted.
- Flush vs. dispatch, issue, or CDB activity in the same cycle: flush wins for all three.
- Reset asserted mid-operation: asynchronous clear to the reset state listed above.

## Test plan
- Reset, then dispatch load tag ps1=5 with rdy=1 in cycle 1 -> `mem_iss.i_valid = 1`, `is_store = 0`, `iss_ps1 = 5` in cycle 2; `count` returns to 0.
- Store with ps1 ready, ps2=9 not ready; CDB port 2 broadcasts 9 in cycle 4 -> issue in cycle 5, not in cycle 4.
- Load A (not ready) at head followed by ready store B -> B does not issue until A issues; order A then B is preserved.
- Fill 8 entries with no issue -> `disp_ready = 0`, `count = 8`, and a 9th dispatch is dropped. Then issue one -> `disp_ready = 1` next cycle; tail wraps to 0 correctly.
- Ready load at head with `stall_load = 1` for 3 cycles -> `i_valid = 0` and `stall_mem_latch = 1` in those cycles; issue in the first cycle stall = 0; a ready store behind it is blocked throughout.
- `br_flush` with 5 entries plus a concurrent dispatch -> `count = 0` and no issue next cycle. Then assert `rst` asynchronously mid-queue -> all outputs go to reset values immediately.
